video_timing_gen: RTL and testbench
===================================

# video_timing_gen

Parameterised raster timing generator that produces the pixel clock-enable, blanking, sync and position counters consumed by the video output chain. It drives the composite-style horizontal blender, the scaler and the HDMI/analog output stages, so every downstream stage sees one pixel-aligned timing source. Counters advance once per pixel enable. All outputs are registered.

## Interface
Parameters:
- CE_DIV, 4: clk cycles per pixel (1..16). A value of 1 holds pix_ce permanently high after reset.
- H_ACTIVE, 640: active pixels per line.
- H_FP, 16: front porch, in pixels.
- H_SYNC, 96: horizontal sync width, in pixels.
- H_BP, 48: back porch, in pixels.
- V_ACTIVE, 480: active lines.
- V_FP, 10: front porch, in lines.
- V_SYNC, 2: vertical sync width, in lines.
- V_BP, 33: back porch, in lines.
- HS_NEG, 1: 1 drives hs active-low.
- VS_NEG, 1: 1 drives vs active-low.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-high reset.
- pix_ce  out  1  one-clk pulse per pixel.
- hblank  out  1  horizontal blanking.
- vblank  out  1  vertical blanking.
- hs  out  1  horizontal sync, at HS_NEG polarity.
- vs  out  1  vertical sync, at VS_NEG polarity.
- de  out  1  data enable, equal to !hblank && !vblank.
- hcount  out  12  pixel position in the line; 0 is the first active pixel.
- vcount  out  12  line position in the frame; 0 is the first active line.
- field  out  1  interlace field. Constant 0 unless interlace is compiled in.

## Operation
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP. Both must be ≤ 4096; violating this is an elaboration error.
- Divider: counts 0..CE_DIV-1 on every clk. pix_ce is registered high on the cycle where the divider wraps.
- On a clk edge where pix_ce=1, hcount advances, wrapping from H_TOTAL-1 to 0.
- On the same edge, when hcount wraps, vcount advances, wrapping from LAST_LINE to 0.
  - LAST_LINE = V_TOTAL-1 normally.
  - LAST_LINE = V_TOTAL when field=1 (interlace build only).
- Outputs are decoded from the next counter values, registered on the same edge, so they always match hcount/vcount.
- hblank = hcount ≥ H_ACTIVE.
- hs_int = H_ACTIVE+H_FP ≤ hcount < H_ACTIVE+H_FP+H_SYNC.
- vblank = vcount ≥ V_ACTIVE.
- vs_int = V_ACTIVE+V_FP ≤ vcount < V_ACTIVE+V_FP+V_SYNC. vs changes only at line start (hcount=0).
- hs = hs_int ^ HS_NEG and vs = vs_int ^ VS_NEG.
- Counter arithmetic: 12-bit unsigned; comparisons use full-width constants.

## Timing
- Reset values:
  - pix_ce=0, hcount=0, vcount=0, field=0, divider=0.
  - hblank=0, vblank=0, de=1.
  - hs=HS_NEG and vs=VS_NEG, i.e. the inactive level.
- First pix_ce is high CE_DIV clks after reset release. With CE_DIV=1 it is high on the first clk after release.
- The first counter advance (to hcount=1) occurs on the edge where pix_ce is first sampled high.
- Between pix_ce pulses all outputs are stable for CE_DIV clks. A consumer sampling on pix_ce sees exactly one value per pixel.
- Reset asserted mid-frame forces all reset values immediately (asynchronously). Counting restarts at (0,0), field 0.
- Frame wrap and line wrap on the same edge: hcount=0, vcount=0, and field toggles, all on that edge.

## Configuration
- VIDEO_TIMING_INTERLACE_EN defined:
  - field toggles on every frame wrap.
  - A frame with field=1 has V_TOTAL+1 lines; the extra line is blanked, with vblank=1 and vs inactive.
  - Field order is 0,1,0,1… from reset.
- Not defined: field is tied to 0, every frame has V_TOTAL lines, and no toggle logic is present.

## Test plan
Small raster used throughout: H_ACTIVE=8, H_FP=2, H_SYNC=3, H_BP=3 (H_TOTAL 16); V_ACTIVE=4, V_FP=1, V_SYNC=2, V_BP=1 (V_TOTAL 8); CE_DIV=2; HS_NEG=1, VS_NEG=0.

- Reset release, CE_DIV=2 -> pix_ce pulses on every 2nd clk; the first pulse is 2 clks after release; hcount=1 after the first pulse edge.
- Horizontal decode -> hblank rises at hcount=8; hs is low for hcount 10..12; de=1 for hcount 0..7 on lines 0..3.
- Vertical decode -> vblank=1 for lines 4..7; vs is high for lines 5..6, with each transition on an edge where hcount=0.
- Wrap -> after 16×8 pixels (256 clks), hcount and vcount both return to 0 on the same edge.
- Reset asserted at hcount=9, vcount=5 -> outputs immediately take reset values (hs=1, vs=0, de=1); a full frame from (0,0) follows release.
- Interlace build -> field goes 0→1 after 128 pixels; the next frame lasts 9 lines (line 8 blanked); field returns to 0 after a further 144 pixels.

Source files
------------

// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing source (pixel enable, blanking, sync, position).
// Optional feature: define VIDEO_TIMING_INTERLACE_EN for an alternating field
// with one extra blanked line on field-1 frames.
module video_timing_gen #(
  parameter int unsigned CE_DIV   = 4,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned HS_NEG   = 1,
  parameter int unsigned VS_NEG   = 1
) (
  input  logic        clk,
  input  logic        reset,
  output logic        pix_ce,
  output logic        hblank,
  output logic        vblank,
  output logic        hs,
  output logic        vs,
  output logic        de,
  output logic [11:0] hcount,
  output logic [11:0] vcount,
  output logic        field
);

  localparam int unsigned CW      = 12;
  localparam int unsigned DIV_W   = 4;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [DIV_W-1:0] DIV_MAX   = DIV_W'(CE_DIV - 1);
  localparam logic [CW-1:0]    H_LAST    = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0]    H_ACT_C   = CW'(H_ACTIVE);
  localparam logic [CW-1:0]    HS_BEG_C  = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0]    HS_END_C  = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0]    V_LAST    = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0]    V_ACT_C   = CW'(V_ACTIVE);
  localparam logic [CW-1:0]    VS_BEG_C  = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0]    VS_END_C  = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic             HS_POL    = 1'(HS_NEG);
  localparam logic             VS_POL    = 1'(VS_NEG);

  // Elaboration-time parameter sanity checks
  if (CE_DIV < 1 || CE_DIV > 16) begin : g_bad_ce_div
    $error("video_timing_gen: CE_DIV must be in 1..16");
  end
  if (H_TOTAL > 4096) begin : g_bad_h_total
    $error("video_timing_gen: H_TOTAL exceeds 4096");
  end
  if (V_TOTAL > 4096) begin : g_bad_v_total
    $error("video_timing_gen: V_TOTAL exceeds 4096");
  end
`ifdef VIDEO_TIMING_INTERLACE_EN
  // The extra field-1 line is numbered V_TOTAL and must fit the 12-bit counter
  if (V_TOTAL > 4095) begin : g_bad_v_total_il
    $error("video_timing_gen: V_TOTAL must be below 4096 with interlace");
  end
`endif

  logic [DIV_W-1:0] div_q, div_d;
  logic             pix_ce_q, pix_ce_d;
  logic [CW-1:0]    hcount_q, hcount_d;
  logic [CW-1:0]    vcount_q, vcount_d;
  logic             hblank_q, hblank_d;
  logic             vblank_q, vblank_d;
  logic             hs_q, hs_d;
  logic             vs_q, vs_d;
  logic             de_q, de_d;
  logic [CW-1:0]    last_line;
  logic             frame_wrap;

`ifdef VIDEO_TIMING_INTERLACE_EN
  logic             field_q, field_d;

  // Field-1 frames run one line longer
  always_comb begin
    last_line = V_LAST;
    if (field_q) last_line = CW'(V_TOTAL);
  end

  // Field flips on every frame wrap
  always_comb begin
    field_d = field_q;
    if (frame_wrap) field_d = ~field_q;
  end

  // Field register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) field_q <= 1'b0;
    else       field_q <= field_d;
  end

  assign field = field_q;
`else
  assign last_line = V_LAST;
  assign field     = 1'b0;
`endif

  // Divider, counter advance and decode of the next position
  always_comb begin
    div_d      = div_q + DIV_W'(1);
    pix_ce_d   = 1'b0;
    hcount_d   = hcount_q;
    vcount_d   = vcount_q;
    frame_wrap = 1'b0;

    if (div_q == DIV_MAX) begin
      div_d    = '0;
      pix_ce_d = 1'b1;
    end

    if (pix_ce_q) begin
      if (hcount_q == H_LAST) begin
        hcount_d = '0;
        if (vcount_q == last_line) begin
          vcount_d   = '0;
          frame_wrap = 1'b1;
        end else begin
          vcount_d = vcount_q + CW'(1);
        end
      end else begin
        hcount_d = hcount_q + CW'(1);
      end
    end

    hblank_d = (hcount_d >= H_ACT_C);
    vblank_d = (vcount_d >= V_ACT_C);
    hs_d     = ((hcount_d >= HS_BEG_C) && (hcount_d < HS_END_C)) ^ HS_POL;
    vs_d     = ((vcount_d >= VS_BEG_C) && (vcount_d < VS_END_C)) ^ VS_POL;
    de_d     = !hblank_d && !vblank_d;
  end

  // Timing state and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q    <= '0;
      pix_ce_q <= 1'b0;
      hcount_q <= '0;
      vcount_q <= '0;
      hblank_q <= 1'b0;
      vblank_q <= 1'b0;
      hs_q     <= HS_POL;
      vs_q     <= VS_POL;
      de_q     <= 1'b1;
    end else begin
      div_q    <= div_d;
      pix_ce_q <= pix_ce_d;
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      hblank_q <= hblank_d;
      vblank_q <= vblank_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      de_q     <= de_d;
    end
  end

  assign pix_ce = pix_ce_q;
  assign hcount = hcount_q;
  assign vcount = vcount_q;
  assign hblank = hblank_q;
  assign vblank = vblank_q;
  assign hs     = hs_q;
  assign vs     = vs_q;
  assign de     = de_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on a 16x8 raster, CE_DIV=2.
module tb_video_timing_gen;

`ifdef VIDEO_TIMING_INTERLACE_EN
  localparam bit IL = 1'b1;
`else
  localparam bit IL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        pix_ce, hblank, vblank, hs, vs, de, field;
  logic [11:0] hcount, vcount;

  int checks = 0;
  int errors = 0;

  // Reference position model
  int m_h, m_v, m_div, cyc;
  bit m_pce, m_f;

  video_timing_gen #(
    .CE_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .HS_NEG(1), .VS_NEG(0)
  ) dut (
    .clk(clk), .reset(reset), .pix_ce(pix_ce), .hblank(hblank), .vblank(vblank),
    .hs(hs), .vs(vs), .de(de), .hcount(hcount), .vcount(vcount), .field(field)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_h = 0; m_v = 0; m_div = 0; m_pce = 1'b0; m_f = 1'b0; cyc = 0;
  endtask

  task automatic check_outputs();
    chk("pix_ce", 32'(pix_ce), 32'(m_pce));
    chk("hcount", 32'(hcount), 32'(m_h));
    chk("vcount", 32'(vcount), 32'(m_v));
    chk("field",  32'(field),  32'(m_f));
    chk("hblank", 32'(hblank), 32'(m_h >= 8));
    chk("hs",     32'(hs),     32'(!(m_h >= 10 && m_h <= 12)));
    chk("vblank", 32'(vblank), 32'(m_v >= 4));
    chk("vs",     32'(vs),     32'(m_v == 5 || m_v == 6));
    chk("de",     32'(de),     32'(m_h < 8 && m_v < 4));
  endtask

  task automatic step();
    int last;
    @(posedge clk);
    if (m_pce) begin
      last = (IL && m_f) ? 8 : 7;
      if (m_h == 15) begin
        m_h = 0;
        if (m_v == last) begin
          m_v = 0;
          if (IL) m_f = ~m_f;
        end else begin
          m_v++;
        end
      end else begin
        m_h++;
      end
    end
    m_pce = (m_div == 1);
    m_div = (m_div == 1) ? 0 : m_div + 1;
    cyc++;
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    int guard;
    reset = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);

    // Reset values
    check_outputs();
    chk("rst_hs", 32'(hs), 32'd1);
    chk("rst_vs", 32'(vs), 32'd0);
    chk("rst_de", 32'(de), 32'd1);

    // Release and first pulse timing
    reset = 1'b0;
    step();
    chk("ce_first_low", 32'(pix_ce), 32'd0);
    step();
    chk("ce_first_high", 32'(pix_ce), 32'd1);
    chk("h_before_adv", 32'(hcount), 32'd0);
    step();
    chk("h_first_adv", 32'(hcount), 32'd1);
    chk("ce_after_adv", 32'(pix_ce), 32'd0);

    // First frame with directed decode points
    while (cyc < 256) begin
      step();
      if (cyc == 15)  chk("hblank_pre",  32'(hblank), 32'd0);
      if (cyc == 17)  chk("hblank_rise", 32'(hblank), 32'd1);
      if (cyc == 21)  chk("hs_low_10",   32'(hs),     32'd0);
      if (cyc == 27)  chk("hs_high_13",  32'(hs),     32'd1);
      if (cyc == 160) chk("vs_pre",      32'(vs),     32'd0);
      if (cyc == 161) chk("vs_rise_h0",  32'(vs),     32'd1);
      if (cyc == 225) chk("vs_fall_h0",  32'(vs),     32'd0);
    end
    chk("pre_wrap_h", 32'(hcount), 32'd15);
    chk("pre_wrap_v", 32'(vcount), 32'd7);
    step();
    chk("wrap_h", 32'(hcount), 32'd0);
    chk("wrap_v", 32'(vcount), 32'd0);
    chk("wrap_field", 32'(field), 32'(IL));

`ifdef VIDEO_TIMING_INTERLACE_EN
    // Field-1 frame: nine lines, line 8 blanked
    while (cyc < 545) begin
      step();
      if (cyc == 513) begin
        chk("il_line8_v",  32'(vcount), 32'd8);
        chk("il_line8_vb", 32'(vblank), 32'd1);
        chk("il_line8_vs", 32'(vs),     32'd0);
        chk("il_line8_f",  32'(field),  32'd1);
      end
    end
    chk("il_wrap_v", 32'(vcount), 32'd0);
    chk("il_field0", 32'(field),  32'd0);
`endif

    // Run to (9,5) then assert reset asynchronously
    guard = 0;
    while (!(m_h == 9 && m_v == 5) && guard < 600) begin
      step();
      guard++;
    end
    chk("reach_9_5", 32'(guard < 600), 32'd1);
    chk("pre_rst_vs", 32'(vs), 32'd1);
    reset = 1'b1;
    #1;
    chk("arst_h",      32'(hcount), 32'd0);
    chk("arst_v",      32'(vcount), 32'd0);
    chk("arst_hs",     32'(hs),     32'd1);
    chk("arst_vs",     32'(vs),     32'd0);
    chk("arst_de",     32'(de),     32'd1);
    chk("arst_hblank", 32'(hblank), 32'd0);
    chk("arst_vblank", 32'(vblank), 32'd0);
    chk("arst_ce",     32'(pix_ce), 32'd0);
    chk("arst_field",  32'(field),  32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();

    // Full frame after release
    reset = 1'b0;
    while (cyc < 256) step();
    chk("f2_pre_wrap_h", 32'(hcount), 32'd15);
    chk("f2_pre_wrap_v", 32'(vcount), 32'd7);
    step();
    chk("f2_wrap_h", 32'(hcount), 32'd0);
    chk("f2_wrap_v", 32'(vcount), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
